// File: rtl/motoro3_step_split_sequencer.sv
// Split-step commutation sequencer: registered outputs one cycle after pwmEnd, no backpressure (pwmEnd is a free-running pulse).
// Optional reverse stepping is compiled in with macro M3_STEP_REVERSE_EN.
module motoro3_step_split_sequencer (
   input  logic        clk,
   input  logic        nRst,
   input  logic        m3r_runEn,
   input  logic        m3r_seqClr,
   input  logic        m3r_dirRev,
   input  logic [1:0]  m3r_stepSplitMax,
   input  logic [15:0] m3r_splitLen,
   input  logic        pwmEnd,
   output logic [3:0]  lcStep,
   output logic [1:0]  m3LpwmSplitStep,
   output logic        m3SplitTick,
   output logic        m3StepTick,
   output logic        m3CycleTick,
   output logic        m3SeqBusy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   logic [1:0]  r_state;
   logic [15:0] r_cnt;
   logic [15:0] r_len;
   logic [1:0]  r_mode;
   logic [1:0]  r_split;
   logic [3:0]  r_step;
   logic        r_split_tick;
   logic        r_step_tick;
   logic        r_cycle_tick;

   logic        w_rev;
   logic        w_bnd;
   logic [15:0] w_len_in;
   logic [1:0]  w_lo;
   logic [1:0]  w_new_lo;
   logic [1:0]  w_split_nxt;
   logic [3:0]  w_step_nxt;
   logic        w_step_bnd;
   logic        w_cyc;

   // Lowest split index used in a step: 4 - splits/step.
   function automatic logic [1:0] lo_of(input logic [1:0] mode);
      case (mode)
         2'd0:    lo_of = 2'd3;
         2'd1:    lo_of = 2'd2;
         default: lo_of = 2'd0;
      endcase
   endfunction

`ifdef M3_STEP_REVERSE_EN
   logic r_dir;
   assign w_rev = r_dir;
`else
   logic w_unused_dir;
   assign w_unused_dir = m3r_dirRev;
   assign w_rev        = 1'b0;
`endif

   assign w_len_in = (m3r_splitLen == 16'd0) ? 16'd1 : m3r_splitLen;
   assign w_lo     = lo_of(r_mode);
   assign w_new_lo = lo_of(m3r_stepSplitMax);
   assign w_bnd    = (r_state != ST_IDLE) && pwmEnd && (r_cnt == (r_len - 16'd1));

   always_comb begin
      w_split_nxt = r_split;
      w_step_nxt  = r_step;
      w_step_bnd  = 1'b0;
      w_cyc       = 1'b0;
      if (w_rev) begin
         if (r_split < 2'd3) begin
            w_split_nxt = r_split + 2'd1;
         end else begin
            // Reverse reload uses the split mode that takes effect for the new step.
            w_step_bnd  = 1'b1;
            w_split_nxt = w_new_lo;
            w_cyc       = (r_step == 4'd0);
            w_step_nxt  = (r_step == 4'd0) ? 4'd11 : r_step - 4'd1;
         end
      end else begin
         if (r_split > w_lo) begin
            w_split_nxt = r_split - 2'd1;
         end else begin
            w_step_bnd  = 1'b1;
            w_split_nxt = 2'd3;
            w_cyc       = (r_step == 4'd11);
            w_step_nxt  = (r_step == 4'd11) ? 4'd0 : r_step + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 16'd0;
         r_len        <= 16'd1;
         r_mode       <= 2'd0;
         r_split      <= 2'd3;
         r_step       <= 4'd0;
         r_split_tick <= 1'b0;
         r_step_tick  <= 1'b0;
         r_cycle_tick <= 1'b0;
`ifdef M3_STEP_REVERSE_EN
         r_dir        <= 1'b0;
`endif
      end else begin
         r_split_tick <= 1'b0;
         r_step_tick  <= 1'b0;
         r_cycle_tick <= 1'b0;
         if (m3r_seqClr) begin
            r_step  <= 4'd0;
            r_split <= 2'd3;
            r_cnt   <= 16'd0;
         end else if (r_state == ST_IDLE) begin
            if (m3r_runEn) begin
               r_state <= ST_RUN;
               r_cnt   <= 16'd0;
               r_mode  <= m3r_stepSplitMax;
               r_len   <= w_len_in;
`ifdef M3_STEP_REVERSE_EN
               r_dir   <= m3r_dirRev;
`endif
            end
         end else begin
            if (w_bnd) begin
               r_cnt        <= 16'd0;
               r_split      <= w_split_nxt;
               r_step       <= w_step_nxt;
               r_len        <= w_len_in;
               r_split_tick <= 1'b1;
               r_step_tick  <= w_step_bnd;
               r_cycle_tick <= w_cyc;
               if (w_step_bnd) begin
                  r_mode <= m3r_stepSplitMax;
`ifdef M3_STEP_REVERSE_EN
                  r_dir  <= m3r_dirRev;
`endif
               end
            end else if (pwmEnd) begin
               r_cnt <= r_cnt + 16'd1;
            end
            // A boundary with run dropped completes the advance and parks immediately.
            if (w_bnd && !m3r_runEn) r_state <= ST_IDLE;
            else if (m3r_runEn)      r_state <= ST_RUN;
            else                     r_state <= ST_STOP;
         end
      end
   end

   assign lcStep          = r_step;
   assign m3LpwmSplitStep = r_split;
   assign m3SplitTick     = r_split_tick;
   assign m3StepTick      = r_step_tick;
   assign m3CycleTick     = r_cycle_tick;
   assign m3SeqBusy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_motoro3_step_split_sequencer.sv
// Bench for motoro3_step_split_sequencer: directed scenarios plus random traffic against a step/split position model.
module tb_motoro3_step_split_sequencer;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        m3r_runEn = 1'b0;
   logic        m3r_seqClr = 1'b0;
   logic        m3r_dirRev = 1'b0;
   logic [1:0]  m3r_stepSplitMax = 2'd0;
   logic [15:0] m3r_splitLen = 16'd1;
   logic        pwmEnd = 1'b0;
   logic [3:0]  lcStep;
   logic [1:0]  m3LpwmSplitStep;
   logic        m3SplitTick, m3StepTick, m3CycleTick, m3SeqBusy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: run mode, period count, splits per step, position and expected ticks.
   int m_mode, m_cnt, m_len, m_n, m_step, m_split, m_rev;
   int e_sp, e_st, e_cy;

   motoro3_step_split_sequencer dut (
      .clk(clk), .nRst(nRst), .m3r_runEn(m3r_runEn), .m3r_seqClr(m3r_seqClr),
      .m3r_dirRev(m3r_dirRev), .m3r_stepSplitMax(m3r_stepSplitMax), .m3r_splitLen(m3r_splitLen),
      .pwmEnd(pwmEnd), .lcStep(lcStep), .m3LpwmSplitStep(m3LpwmSplitStep),
      .m3SplitTick(m3SplitTick), .m3StepTick(m3StepTick), .m3CycleTick(m3CycleTick),
      .m3SeqBusy(m3SeqBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int splits_per_step(input int mode);
      return (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_len = 1; m_n = 1; m_step = 0; m_split = 3; m_rev = 0;
      e_sp = 0; e_st = 0; e_cy = 0;
   endtask

   task automatic model_new_step(input int mode, input int rev);
      m_n = splits_per_step(mode);
`ifdef M3_STEP_REVERSE_EN
      m_rev = rev;
`endif
   endtask

   task automatic model_boundary(input int mode, input int rev, input int len);
      e_sp  = 1;
      m_len = (len == 0) ? 1 : len;
      if (m_rev == 0) begin
         if (m_split > 4 - m_n) m_split--;
         else begin
            m_split = 3;
            m_step  = (m_step + 1) % 12;
            e_st = 1; e_cy = (m_step == 0);
            model_new_step(mode, rev);
         end
      end else begin
         if (m_split < 3) m_split++;
         else begin
            model_new_step(mode, rev);
            m_split = 4 - m_n;
            m_step  = (m_step + 11) % 12;
            e_st = 1; e_cy = (m_step == 11);
         end
      end
   endtask

   task automatic model_update(input int run, input int clr, input int rev, input int mode,
                               input int len, input int pwm);
      int bnd;
      e_sp = 0; e_st = 0; e_cy = 0; bnd = 0;
      if (clr != 0) begin
         m_step = 0; m_split = 3; m_cnt = 0;
      end else if (m_mode == 0) begin
         if (run != 0) begin
            m_mode = 1; m_cnt = 0;
            m_len  = (len == 0) ? 1 : len;
            model_new_step(mode, rev);
         end
      end else begin
         if (pwm != 0) begin
            if (m_cnt + 1 >= m_len) begin
               bnd = 1; m_cnt = 0;
               model_boundary(mode, rev, len);
            end else m_cnt++;
         end
         m_mode = (bnd != 0 && run == 0) ? 0 : (run != 0) ? 1 : 2;
      end
   endtask

   task automatic cyc(input bit run, input bit clr, input bit rev, input bit [1:0] mode,
                      input bit [15:0] len, input bit pwm);
      m3r_runEn = run; m3r_seqClr = clr; m3r_dirRev = rev;
      m3r_stepSplitMax = mode; m3r_splitLen = len; pwmEnd = pwm;
      @(posedge clk);
      #1;
      model_update(run, clr, rev, mode, len, pwm);
      chk("lcStep", lcStep, m_step);
      chk("split", m3LpwmSplitStep, m_split);
      chk("splitTick", m3SplitTick, e_sp);
      chk("stepTick", m3StepTick, e_st);
      chk("cycleTick", m3CycleTick, e_cy);
      chk("busy", m3SeqBusy, (m_mode != 0) ? 1 : 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      m3r_runEn = 0; m3r_seqClr = 0; m3r_dirRev = 0; pwmEnd = 0;
      nRst = 0;
      #2;
      model_reset();
      chk("rst_lcStep", lcStep, 0);
      chk("rst_split", m3LpwmSplitStep, 3);
      chk("rst_ticks", {m3SplitTick, m3StepTick, m3CycleTick}, 0);
      chk("rst_busy", m3SeqBusy, 0);
      @(negedge clk);
      nRst = 1;
   endtask

   initial begin
      int n_sp, n_st, n_cy;
      bit run;

      // Full electrical cycle at 4 splits/step, one period per split.
      do_reset();
      cyc(1, 0, 0, 2, 1, 0);
      n_sp = 0; n_st = 0; n_cy = 0;
      for (int i = 1; i <= 48; i++) begin
         cyc(1, 0, 0, 2, 1, 1);
         if (i <= 4) chk("s1_seq", m3LpwmSplitStep, (i == 4) ? 3 : 3 - i);
         n_sp += m3SplitTick; n_st += m3StepTick; n_cy += m3CycleTick;
      end
      chk("s1_splitTicks", n_sp, 48);
      chk("s1_stepTicks", n_st, 12);
      chk("s1_cycleTicks", n_cy, 1);
      chk("s1_step", lcStep, 0);
      chk("s1_split", m3LpwmSplitStep, 3);

      // Two splits/step, three periods per split.
      do_reset();
      cyc(1, 0, 0, 1, 3, 0);
      for (int i = 1; i <= 6; i++) begin
         cyc(1, 0, 0, 1, 3, 1);
         if (i == 2) chk("s2_p2_split", m3LpwmSplitStep, 3);
         if (i == 3) chk("s2_p3_split", m3LpwmSplitStep, 2);
         if (i == 3) chk("s2_p3_step", lcStep, 0);
      end
      chk("s2_p6_split", m3LpwmSplitStep, 3);
      chk("s2_p6_step", lcStep, 1);

      // splitLen 0 acts as 1: every pulse is a step.
      do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         cyc(1, 0, 0, 0, 0, 1);
         chk("s3_step", lcStep, i);
         chk("s3_split", m3LpwmSplitStep, 3);
      end

      // Clear beats a simultaneous pulse at lcStep 7.
      cyc(1, 1, 0, 0, 0, 1);
      chk("s4_step", lcStep, 0);
      chk("s4_split", m3LpwmSplitStep, 3);
      chk("s4_ticks", {m3SplitTick, m3StepTick, m3CycleTick}, 0);
      chk("s4_busy", m3SeqBusy, 1);

      // Run dropped mid-split finishes that split, then parks.
      do_reset();
      cyc(1, 0, 0, 2, 4, 0);
      cyc(1, 0, 0, 2, 4, 1);
      cyc(1, 0, 0, 2, 4, 1);
      cyc(0, 0, 0, 2, 4, 0);
      chk("s5_busy_drop", m3SeqBusy, 1);
      cyc(0, 0, 0, 2, 4, 1);
      chk("s5_busy_p3", m3SeqBusy, 1);
      cyc(0, 0, 0, 2, 4, 1);
      chk("s5_busy_p4", m3SeqBusy, 0);
      chk("s5_split_p4", m3LpwmSplitStep, 2);
      cyc(0, 0, 0, 2, 4, 1);
      chk("s5_split_idle", m3LpwmSplitStep, 2);
      chk("s5_step_idle", lcStep, 0);
      chk("s5_tick_idle", m3SplitTick, 0);

`ifdef M3_STEP_REVERSE_EN
      do_reset();
      cyc(1, 0, 1, 2, 1, 0);
      cyc(1, 0, 1, 2, 1, 1);
      chk("s6_step", lcStep, 11);
      chk("s6_split", m3LpwmSplitStep, 0);
      chk("s6_cycle", m3CycleTick, 1);
`endif

      // Random traffic: run mostly held, occasional drops, clears and mode/length changes.
      do_reset();
      run = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) run = ~run;
         cyc(run, ($urandom_range(0, 49) == 0), $urandom_range(0, 1),
             2'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
             ($urandom_range(0, 9) < 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/motoro3_step_split_sequencer.md
MOTORO3_STEP_SPLIT_SEQUENCER -- requirements
Module: motoro3_step_split_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port nRst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port m3r_runEn, input, 1 bit: level run request.
REQ-004 SHALL have port m3r_seqClr, input, 1 bit: synchronous clear pulse.
REQ-005 SHALL have port m3r_dirRev, input, 1 bit: reverse-direction request; honoured only per REQ-027.
REQ-006 SHALL have port m3r_stepSplitMax, input, 2 bits: split mode; 0 = 1 split/step, 1 = 2 splits/step, 2 or 3 = 4 splits/step.
REQ-007 SHALL have port m3r_splitLen, input, 16 bits: PWM periods per split; 0 is treated as 1.
REQ-008 SHALL have port pwmEnd, input, 1 bit: one-cycle pulse at each PWM period end.
REQ-009 SHALL have port lcStep, output, 4 bits: commutation step, 0..11.
REQ-010 SHALL have port m3LpwmSplitStep, output, 2 bits: sub-step index inside the step.
REQ-011 SHALL have ports m3SplitTick, m3StepTick and m3CycleTick, outputs, 1 bit each: one-cycle event pulses.
REQ-012 SHALL have port m3SeqBusy, output, 1 bit: high when the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, RUN and STOPPING.
- IDLE -> RUN when m3r_runEn=1.
- RUN -> STOPPING when m3r_runEn=0.
- STOPPING -> IDLE at the next split boundary.
- STOPPING -> RUN if m3r_runEn returns to 1 before that boundary.
REQ-014 SHALL keep a 16-bit period counter; in RUN or STOPPING it increments on each pwmEnd, and on the pwmEnd where counter == effective splitLen-1 it clears to 0, giving a split boundary.
REQ-015 SHALL ignore pwmEnd in IDLE.
REQ-016 SHALL, at each forward split boundary, decrement the split index, where N = splits/step latched from m3r_stepSplitMax:
- while split > 4-N, decrement split;
- otherwise reload split=3 and advance lcStep.
REQ-017 SHALL hold m3LpwmSplitStep at 3 when N=1.
REQ-018 SHALL advance lcStep forward 0->1->...->11->0; the wrap 11->0 asserts m3CycleTick.
REQ-019 SHALL latch m3r_stepSplitMax only at step boundaries, and when leaving IDLE.
REQ-020 SHALL latch m3r_splitLen only at split boundaries, and when leaving IDLE.
REQ-021 SHALL update outputs in the clock cycle after the pwmEnd cycle (registered, 1-cycle latency); the tick pulses are high for exactly that one cycle.
REQ-022 SHALL assert m3SplitTick on every split boundary, and m3StepTick additionally when lcStep changes.
REQ-023 SHALL give m3r_seqClr priority over pwmEnd and over state transitions: it sets lcStep=0, split=3 and counter=0, generates no ticks, and leaves the state unchanged.
REQ-024 SHALL, when m3r_runEn falls in the same cycle as a boundary pwmEnd, perform the advance and go directly to IDLE.
REQ-025 SHALL, in IDLE, hold lcStep and m3LpwmSplitStep; a restart resumes from the held position with counter=0.

Reset
REQ-026 SHALL, while nRst=0, asynchronously force:
- state IDLE, counter 0;
- lcStep=0, m3LpwmSplitStep=3;
- all ticks 0, m3SeqBusy=0;
- latched split mode 0, latched splitLen 1.

Configuration
REQ-027 SHALL support the macro M3_STEP_REVERSE_EN.
- When defined and m3r_dirRev=1, a split boundary increments split up to 3, then reloads split=4-N and decrements lcStep (0->11 wraps and asserts m3CycleTick).
- m3r_dirRev is sampled at step boundaries only.
- When not defined, m3r_dirRev is ignored and the sequence is forward only.

Verification
REQ-028 SHALL cover: stepSplitMax=2, splitLen=1, runEn=1, 48 pwmEnd pulses -> split cycles 3,2,1,0 per step; 48 m3SplitTick, 12 m3StepTick, 1 m3CycleTick; final lcStep=0, split=3.
REQ-029 SHALL cover: stepSplitMax=1, splitLen=3, 6 pwmEnd pulses -> split 3->2 after pulse 3; split 2->3 with lcStep 0->1 after pulse 6.
REQ-030 SHALL cover: splitLen=0, stepSplitMax=0 -> every pwmEnd advances lcStep; split stays 3.
REQ-031 SHALL cover: m3r_seqClr together with pwmEnd at lcStep=7 -> lcStep=0, split=3, no ticks.
REQ-032 SHALL cover: runEn dropped mid-split (splitLen=4, after 2 pulses) -> m3SeqBusy stays 1 until the 4th pulse, then IDLE with positions held; a further pwmEnd changes nothing.
REQ-033 SHALL cover, with M3_STEP_REVERSE_EN, dirRev=1, stepSplitMax=2, from lcStep=0/split=3 -> next boundary gives lcStep=11, split=0 and m3CycleTick=1.
